// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t    - fetch FSM states (REQ, WAIT, DROP, HALT)
//   fetch_entry_t    - one instruction buffer entry {pc, instr, fault}
//   DEFAULT_RESET_PC - default first fetch address after reset
`timescale 1ns/1ps

package fetch_pkg;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_entry_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous instruction buffer FIFO.
//   clk_i       clock, rising edge
//   rstN_i      synchronous active-low reset
//   clear_i     synchronous clear (empties the buffer)
//   push_i      write pushData_i this cycle
//   pushData_i  entry to write
//   pop_i       remove the head entry this cycle
//   head_o      current head entry (meaningful when not empty)
//   count_o     number of stored entries
//   full_o      count_o == DEPTH
//   empty_o     count_o == 0
// DEPTH must be a power of two so the pointers wrap naturally.
`timescale 1ns/1ps

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rstN_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  fetch_entry_t             pushData_i,
    input  logic                     pop_i,
    output fetch_entry_t             head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pushEn;
    logic             popEn;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rdPtr_q];

    // A push into a full buffer is accepted when the head leaves in the
    // same cycle, so a full FIFO can stream at one entry per cycle.
    assign popEn  = pop_i && !empty_o;
    assign pushEn = push_i && (!full_o || popEn);

    // Next-state pointers and occupancy.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushEn) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(pushEn) - CNT_W'(popEn);
    end

    // Pointer/count registers; clear behaves like reset for occupancy.
    always_ff @(posedge clk_i) begin
        if (!rstN_i || clear_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk_i) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
// Holds the PC, issues single-outstanding word reads, buffers returned
// instructions with their PCs and hands them to the decoder via valid/ready.
// Redirects flush the buffer and discard any in-flight response.
//   i_clk, i_rst_n        clock / synchronous active-low reset
//   o_imem_req/_addr      read request and address (address == pc)
//   i_imem_gnt            request accepted
//   i_imem_rvalid/_rdata  read response, i_imem_err qualified by rvalid
//   i_redirect/_addr      flush and restart fetch at a new PC
//   o_valid, i_ready      decoder handshake
//   o_opcode, o_pc        head entry instruction/PC (0 when !o_valid)
//   o_fetch_fault         head entry is a bus error or misaligned PC
// Build option FETCH_BYPASS_EN: a response arriving at an empty buffer is
// presented combinationally in the same cycle.
`timescale 1ns/1ps

module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_err,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_addr,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_opcode,
    output logic [31:0] o_pc,
    output logic        o_fetch_fault
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      reqPc_q, reqPc_d;
    logic             started_q;

    logic             granted;
    logic             hasSpace;
    logic             aligned;
    logic             faultPush;
    logic             respValid;
    logic             bypassHit;
    fetch_entry_t     respEntry;
    fetch_entry_t     faultEntry;
    fetch_entry_t     outEntry;

    logic             fifoPush;
    logic             fifoPop;
    logic             fifoClear;
    fetch_entry_t     fifoPushData;
    fetch_entry_t     fifoHead;
    logic [CNT_W-1:0] fifoCount;
    logic             fifoFull;
    logic             fifoEmpty;

    assign aligned  = (pc_q[1:0] == 2'b00);
    assign hasSpace = (fifoCount < CNT_W'(FIFO_DEPTH));

    // started_q keeps the request low in the first cycle after reset release.
    assign o_imem_req  = started_q && (state_q == REQ) && hasSpace && aligned;
    assign o_imem_addr = pc_q;
    assign granted     = o_imem_req && i_imem_gnt;

    assign respEntry  = '{pc: reqPc_q, instr: i_imem_rdata, fault: i_imem_err};
    assign faultEntry = '{pc: pc_q, instr: 32'h0, fault: 1'b1};

    // Next-state logic. Redirect overrides everything; DROP is entered only
    // when a response is still owed after this cycle, so a response that
    // lands together with the redirect does not leave the FSM waiting forever.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        reqPc_d   = reqPc_q;
        faultPush = 1'b0;
        respValid = 1'b0;
        if (i_redirect) begin
            pc_d = i_redirect_addr;
            if (granted ||
                (((state_q == WAIT) || (state_q == DROP)) && !i_imem_rvalid)) begin
                state_d = DROP;
            end else begin
                state_d = REQ;
            end
        end else begin
            case (state_q)
                REQ: begin
                    if (started_q) begin
                        if (!aligned) begin
                            if (!fifoFull) begin
                                faultPush = 1'b1;
                                state_d   = HALT;
                            end
                        end else if (granted) begin
                            pc_d    = pc_q + 32'd4;
                            reqPc_d = pc_q;
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (i_imem_rvalid) begin
                        respValid = 1'b1;
                        state_d   = i_imem_err ? HALT : REQ;
                    end
                end
                DROP: begin
                    if (i_imem_rvalid) begin
                        state_d = REQ;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = REQ;
                end
            endcase
        end
    end

    // State, PC and captured request PC registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= REQ;
            pc_q      <= RESET_PC;
            reqPc_q   <= '0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            reqPc_q   <= reqPc_d;
            started_q <= 1'b1;
        end
    end

`ifdef FETCH_BYPASS_EN
    // A response to an empty buffer is shown directly; it only needs
    // storing if the decoder does not take it this cycle.
    assign bypassHit = fifoEmpty && respValid;
    assign fifoPush  = faultPush || (respValid && !(bypassHit && i_ready));
`else
    assign bypassHit = 1'b0;
    assign fifoPush  = faultPush || respValid;
`endif

    assign fifoPushData = faultPush ? faultEntry : respEntry;
    assign fifoPop      = i_ready && !fifoEmpty && !i_redirect;
    assign fifoClear    = i_redirect;

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (i_clk),
        .rstN_i    (i_rst_n),
        .clear_i   (fifoClear),
        .push_i    (fifoPush),
        .pushData_i(fifoPushData),
        .pop_i     (fifoPop),
        .head_o    (fifoHead),
        .count_o   (fifoCount),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty)
    );

    // Decoder-facing outputs are zeroed whenever nothing is valid.
    always_comb begin
        o_valid       = !fifoEmpty || bypassHit;
        outEntry      = bypassHit ? respEntry : fifoHead;
        o_opcode      = 32'h0;
        o_pc          = 32'h0;
        o_fetch_fault = 1'b0;
        if (o_valid) begin
            o_opcode      = outEntry.instr;
            o_pc          = outEntry.pc;
            o_fetch_fault = outEntry.fault;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit.
// A small memory model grants every request at once and answers after a
// programmable number of cycles with 0x00000013, optionally flagging a
// bus error at one address. Checks are made #1 after each falling edge.
`timescale 1ns/1ps

module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    wire         i_imem_gnt;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic        i_imem_err = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_addr = 32'h0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_opcode;
    logic [31:0] o_pc;
    logic        o_fetch_fault;

    int errors = 0;
    int checks = 0;

    int          memDelay = 1;
    bit          memErrEn = 1'b0;
    logic [31:0] memErrAddr = 32'h0;
    bit          pendActive = 1'b0;
    int          pendCnt = 0;
    logic [31:0] pendAddr = 32'h0;

    wire [65:0] outVec = {o_valid, o_fetch_fault, o_pc, o_opcode};
    wire [32:0] reqVec = {o_imem_req, o_imem_addr};

    fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_gnt     (i_imem_gnt),
        .i_imem_rvalid  (i_imem_rvalid),
        .i_imem_rdata   (i_imem_rdata),
        .i_imem_err     (i_imem_err),
        .i_redirect     (i_redirect),
        .i_redirect_addr(i_redirect_addr),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_opcode       (o_opcode),
        .o_pc           (o_pc),
        .o_fetch_fault  (o_fetch_fault)
    );

    always #5 i_clk = ~i_clk;

    // Memory grants immediately.
    assign i_imem_gnt = o_imem_req;

    // Memory response model: evaluated on the falling edge so its outputs
    // are stable for the next rising edge.
    always @(negedge i_clk) begin
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        i_imem_err    = 1'b0;
        if (pendActive) begin
            if (pendCnt <= 1) begin
                i_imem_rvalid = 1'b1;
                i_imem_rdata  = NOP;
                i_imem_err    = memErrEn && (pendAddr == memErrAddr);
                pendActive    = 1'b0;
            end else begin
                pendCnt = pendCnt - 1;
            end
        end
        if (o_imem_req && i_imem_gnt) begin
            pendActive = 1'b1;
            pendCnt    = memDelay;
            pendAddr   = o_imem_addr;
        end
    end

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (reqVec !== {1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL reset_req: got %h expected %h", reqVec, {1'b0, 32'h0});
        end
        checks++;
        if (outVec !== 66'h0) begin
            errors++;
            $display("[TB] FAIL reset_out: got %h expected %h", outVec, 66'h0);
        end
        i_rst_n = 1'b1;
        checks++;
        if (reqVec !== {1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL release_cycle_req: got %h expected %h", reqVec, {1'b0, 32'h0});
        end
        tick();
        checks++;
        if (reqVec !== {1'b1, 32'h0}) begin
            errors++;
            $display("[TB] FAIL first_req: got %h expected %h", reqVec, {1'b1, 32'h0});
        end
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (outVec !== 66'h0 || reqVec !== {1'b0, 32'(4 * k + 4)}) begin
                errors++;
                $display("[TB] FAIL stream_gap%0d: got out=%h req=%h expected out=0 req=%h",
                         k, outVec, reqVec, {1'b0, 32'(4 * k + 4)});
            end
            tick();
            checks++;
            if (outVec !== {1'b1, 1'b0, 32'(4 * k), NOP}) begin
                errors++;
                $display("[TB] FAIL stream_out%0d: got %h expected %h",
                         k, outVec, {1'b1, 1'b0, 32'(4 * k), NOP});
            end
            checks++;
            if (reqVec !== {1'b1, 32'(4 * k + 4)}) begin
                errors++;
                $display("[TB] FAIL stream_req%0d: got %h expected %h",
                         k, reqVec, {1'b1, 32'(4 * k + 4)});
            end
        end
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (outVec !== {1'b1, 1'b0, 32'h8, NOP} || reqVec !== {1'b0, 32'h10}) begin
                errors++;
                $display("[TB] FAIL full_hold%0d: got out=%h req=%h expected out=%h req=%h",
                         k, outVec, reqVec, {1'b1, 1'b0, 32'h8, NOP}, {1'b0, 32'h10});
            end
        end
        i_ready = 1'b1;
        tick();
        checks++;
        if (reqVec !== {1'b1, 32'h10} || outVec !== {1'b1, 1'b0, 32'hC, NOP}) begin
            errors++;
            $display("[TB] FAIL resume_after_pop: got out=%h req=%h expected out=%h req=%h",
                     outVec, reqVec, {1'b1, 1'b0, 32'hC, NOP}, {1'b1, 32'h10});
        end
        tick();
        checks++;
        if (outVec !== 66'h0 || reqVec !== {1'b0, 32'h14}) begin
            errors++;
            $display("[TB] FAIL drain_gap: got out=%h req=%h expected out=0 req=%h",
                     outVec, reqVec, {1'b0, 32'h14});
        end
        memDelay = 3;
        tick();
        checks++;
        if (outVec !== {1'b1, 1'b0, 32'h10, NOP} || reqVec !== {1'b1, 32'h14}) begin
            errors++;
            $display("[TB] FAIL drain_next: got out=%h req=%h expected out=%h req=%h",
                     outVec, reqVec, {1'b1, 1'b0, 32'h10, NOP}, {1'b1, 32'h14});
        end
    endtask

    task automatic test_redirect();
        tick();
        checks++;
        if (reqVec !== {1'b0, 32'h18}) begin
            errors++;
            $display("[TB] FAIL wait_state_req: got %h expected %h", reqVec, {1'b0, 32'h18});
        end
        i_redirect      = 1'b1;
        i_redirect_addr = 32'h100;
        tick();
        i_redirect = 1'b0;
        checks++;
        if (outVec !== 66'h0 || reqVec !== {1'b0, 32'h100}) begin
            errors++;
            $display("[TB] FAIL redirect_drop: got out=%h req=%h expected out=0 req=%h",
                     outVec, reqVec, {1'b0, 32'h100});
        end
        tick();
        checks++;
        if (reqVec !== {1'b0, 32'h100}) begin
            errors++;
            $display("[TB] FAIL late_resp_no_req: got %h expected %h", reqVec, {1'b0, 32'h100});
        end
        memDelay = 1;
        tick();
        checks++;
        if (outVec !== 66'h0 || reqVec !== {1'b1, 32'h100}) begin
            errors++;
            $display("[TB] FAIL late_resp_dropped: got out=%h req=%h expected out=0 req=%h",
                     outVec, reqVec, {1'b1, 32'h100});
        end
        tick();
        tick();
        checks++;
        if (outVec !== {1'b1, 1'b0, 32'h100, NOP}) begin
            errors++;
            $display("[TB] FAIL redirect_first_pc: got %h expected %h",
                     outVec, {1'b1, 1'b0, 32'h100, NOP});
        end
    endtask

    task automatic test_bus_error();
        tick();
        tick();
        checks++;
        if (outVec !== {1'b1, 1'b0, 32'h104, NOP} || reqVec !== {1'b1, 32'h108}) begin
            errors++;
            $display("[TB] FAIL pre_error_stream: got out=%h req=%h expected out=%h req=%h",
                     outVec, reqVec, {1'b1, 1'b0, 32'h104, NOP}, {1'b1, 32'h108});
        end
        // Redirect coincides with a grant, so that response must be dropped.
        i_redirect      = 1'b1;
        i_redirect_addr = 32'h8;
        memErrEn        = 1'b1;
        memErrAddr      = 32'h8;
        tick();
        i_redirect = 1'b0;
        checks++;
        if (outVec !== 66'h0 || reqVec !== {1'b0, 32'h8}) begin
            errors++;
            $display("[TB] FAIL redirect_on_grant: got out=%h req=%h expected out=0 req=%h",
                     outVec, reqVec, {1'b0, 32'h8});
        end
        tick();
        checks++;
        if (reqVec !== {1'b1, 32'h8}) begin
            errors++;
            $display("[TB] FAIL error_addr_req: got %h expected %h", reqVec, {1'b1, 32'h8});
        end
        tick();
        tick();
        checks++;
        if (outVec !== {1'b1, 1'b1, 32'h8, NOP} || reqVec !== {1'b0, 32'hC}) begin
            errors++;
            $display("[TB] FAIL error_entry: got out=%h req=%h expected out=%h req=%h",
                     outVec, reqVec, {1'b1, 1'b1, 32'h8, NOP}, {1'b0, 32'hC});
        end
        tick();
        tick();
        checks++;
        if (outVec !== 66'h0 || reqVec !== {1'b0, 32'hC}) begin
            errors++;
            $display("[TB] FAIL error_halt: got out=%h req=%h expected out=0 req=%h",
                     outVec, reqVec, {1'b0, 32'hC});
        end
        memErrEn        = 1'b0;
        i_redirect      = 1'b1;
        i_redirect_addr = 32'h20;
        tick();
        i_redirect = 1'b0;
        checks++;
        if (reqVec !== {1'b1, 32'h20}) begin
            errors++;
            $display("[TB] FAIL halt_exit_req: got %h expected %h", reqVec, {1'b1, 32'h20});
        end
        tick();
        tick();
        checks++;
        if (outVec !== {1'b1, 1'b0, 32'h20, NOP}) begin
            errors++;
            $display("[TB] FAIL halt_exit_out: got %h expected %h",
                     outVec, {1'b1, 1'b0, 32'h20, NOP});
        end
    endtask

    task automatic test_misaligned();
        i_redirect      = 1'b1;
        i_redirect_addr = 32'h102;
        tick();
        i_redirect = 1'b0;
        tick();
        checks++;
        if (outVec !== 66'h0 || reqVec !== {1'b0, 32'h102}) begin
            errors++;
            $display("[TB] FAIL misaligned_no_req: got out=%h req=%h expected out=0 req=%h",
                     outVec, reqVec, {1'b0, 32'h102});
        end
        tick();
        checks++;
        if (outVec !== {1'b1, 1'b1, 32'h102, 32'h0} || reqVec !== {1'b0, 32'h102}) begin
            errors++;
            $display("[TB] FAIL misaligned_entry: got out=%h req=%h expected out=%h req=%h",
                     outVec, reqVec, {1'b1, 1'b1, 32'h102, 32'h0}, {1'b0, 32'h102});
        end
        tick();
        tick();
        checks++;
        if (outVec !== 66'h0 || reqVec !== {1'b0, 32'h102}) begin
            errors++;
            $display("[TB] FAIL misaligned_halt: got out=%h req=%h expected out=0 req=%h",
                     outVec, reqVec, {1'b0, 32'h102});
        end
    endtask

    task automatic test_latency();
        logic [65:0] expAtResp;
        logic [65:0] expAfter;
        expAtResp = BYPASS ? {1'b1, 1'b0, 32'h200, NOP} : 66'h0;
        expAfter  = BYPASS ? 66'h0 : {1'b1, 1'b0, 32'h200, NOP};
        i_redirect      = 1'b1;
        i_redirect_addr = 32'h200;
        tick();
        i_redirect = 1'b0;
        checks++;
        if (reqVec !== {1'b1, 32'h200}) begin
            errors++;
            $display("[TB] FAIL redirect_req_next_cycle: got %h expected %h",
                     reqVec, {1'b1, 32'h200});
        end
        tick();
        checks++;
        if (outVec !== expAtResp) begin
            errors++;
            $display("[TB] FAIL latency_resp_cycle: got %h expected %h", outVec, expAtResp);
        end
        tick();
        checks++;
        if (outVec !== expAfter) begin
            errors++;
            $display("[TB] FAIL latency_next_cycle: got %h expected %h", outVec, expAfter);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_bus_error();
        test_misaligned();
        test_latency();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
